cmp_branch_seq: RTL
===================

# cmp_branch_seq

Multi-cycle instruction sequencer for the 16-bit lab datapath. It fetches instruction words over a simple request/acknowledge port and decodes them. It drives the compare unit's enable and condition select, then resolves conditional branches from the compare unit's single condition-true flag `F`. It sits between instruction memory, the register file write port and the compare unit, and owns the program counter.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request, held high in FETCH until acknowledged.
- `imem_addr`  out  16  fetch address, always equal to `pc`.
- `imem_ack`  in  1  fetch acknowledge; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  16  instruction word.
- `cmp_en`  out  1  one-cycle pulse that updates the compare unit's flags at the next edge.
- `cmp_cond`  out  4  condition select; always equal to `ir[11:8]`.
- `cmp_f`  in  1  condition-true flag from the compare unit (combinational from flags and `cmp_cond`).
- `rf_raddr_n`, `rf_raddr_m`  out  4 each  register read addresses; equal to `ir[7:4]` and `ir[3:0]`.
- `rf_we`  out  1  register write enable, one-cycle pulse.
- `rf_waddr`  out  4  write address; equal to `ir[11:8]`.
- `pc`  out  16  program counter.
- `halted`  out  1  high while in HALT.
- `resume`  in  1  leaves HALT when sampled high.
- `illegal`  out  1  sticky flag, set when an undefined opcode is decoded.
- `retired`  out  16  count of retired instructions; wraps modulo 2^16.

## Operation
- Instruction format: `ir[15:12]` opcode; `ir[11:8]` rd or cond; `ir[7:4]` rn; `ir[3:0]` rm; for branches, `ir[7:0]` is a signed 8-bit offset.
- Opcodes:
  - 0x0 NOP.
  - 0x1 CMP: `cmp_en` pulses in EXEC.
  - 0x2 B: if `cmp_f`=1 in EXEC, then `pc <= pc + sext(ir[7:0])`; otherwise `pc <= pc + 1`.
  - 0x3 ALU: `rf_we` pulses in WB.
  - 0xF HALT.
  - Any other opcode executes as a NOP and sets `illegal`.
- State machine:
  - FETCH: `imem_req`=1. On `imem_ack`=1, `ir <= imem_rdata`, go to DECODE. Otherwise stay in FETCH.
  - DECODE: one cycle; selects the next state from the opcode. HALT goes to HALT; everything else goes to EXEC.
  - EXEC: one cycle. CMP pulses `cmp_en`. B resolves the branch. ALU goes to WB. All other instructions go to FETCH.
  - WB: one cycle; `rf_we`=1, then go to FETCH.
  - HALT: `halted`=1. When `resume`=1, `pc <= pc + 1` and go to FETCH.
- PC update: `pc <= pc + 1` when leaving EXEC or WB, except for a taken branch. All PC arithmetic is 16-bit and wraps: 16'hFFFF + 1 = 16'h0000. The branch offset is sign-extended to 16 bits before the add.
- `retired` increments once per instruction: on leaving EXEC, on leaving WB, and on entering HALT.
- `illegal` is cleared only by reset.

## Timing
- Reset (asynchronous, immediate): state=FETCH, `pc`=`RESET_PC`, `ir`=16'h0000, `retired`=0, `illegal`=0. Outputs during reset: `imem_req`=0, `cmp_en`=0, `rf_we`=0, `halted`=0.
- `imem_req` rises in the first cycle after `rst_n` deasserts.
- Reset asserted during an outstanding fetch drops `imem_req` immediately and discards any acknowledge. The fetch restarts at `RESET_PC`.
- `imem_ack` is ignored in every state other than FETCH.
- Latency with zero-wait memory (acknowledge in the first request cycle):
  - NOP, CMP and B: 3 cycles (FETCH, DECODE, EXEC).
  - ALU: 4 cycles.
  - Each cycle without an acknowledge adds 1 cycle in FETCH.
- CMP followed directly by B: the flags update at the edge that ends the CMP's EXEC. The branch samples `cmp_f` in its own EXEC cycle at least 3 cycles later, so the branch always sees the new flags.
- `cmp_en` and `rf_we` are registered-state decodes: exactly one cycle wide, with no glitch between instructions.
- `resume` high in the same cycle HALT is entered takes effect at the next edge; HALT lasts at least 1 cycle.

## Test plan
- Reset/fetch: `RESET_PC`=0x0010, release `rst_n`, hold `imem_ack` low for 3 cycles, then drive ack with 0x0000. Required: `imem_addr`=0x0010 throughout, `ir` captured, `pc`=0x0011 after EXEC, `retired`=1.
- CMP then taken branch: at pc 0x0000 fetch 0x1012, then at 0x0001 fetch 0x20FE with `cmp_f`=1. Required: `cmp_en` pulses exactly once, `cmp_cond`=0x0, next `pc`=0xFFFF.
- Not-taken branch: at 0x0005 fetch 0x2E03 with `cmp_f`=0. Required: `pc`=0x0006; with `cmp_f`=1, `pc`=0x0008.
- ALU writeback: fetch 0x3A45. Required: `rf_raddr_n`=4, `rf_raddr_m`=5, `rf_we` high for exactly 1 cycle with `rf_waddr`=0xA, 4 cycles total.
- Halt/resume and illegal: at pc 0x0002 fetch 0x7000, then 0xF000. Required: `illegal`=1 (sticky), `halted`=1, `retired`=2, no `imem_req` while halted. Pulse `resume`: `pc`=0x0004, fetch resumes.
- Reset mid-fetch and wrap: `pc`=0xFFFF executing NOP gives `pc`=0x0000. Assert `rst_n`=0 while `imem_req`=1 and ack=1. Required: `imem_req`=0 immediately, `ir` unchanged from its reset value 0x0000.

Source files
------------

// File: rtl/cmp_branch_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit lab datapath.
// Owns the PC, drives the compare unit and resolves branches from its F flag.
module cmp_branch_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        cmp_en,
  output logic [3:0]  cmp_cond,
  input  logic        cmp_f,
  output logic [3:0]  rf_raddr_n,
  output logic [3:0]  rf_raddr_m,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] pc,
  output logic        halted,
  input  logic        resume,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_CMP  = 4'h1;
  localparam logic [3:0] OP_B    = 4'h2;
  localparam logic [3:0] OP_ALU  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        imem_req_q, imem_req_d;
  logic        cmp_en_q, cmp_en_d;
  logic        rf_we_q, rf_we_d;
  logic        halted_q, halted_d;

  logic [3:0]  opcode;
  logic        op_known;
  logic [15:0] pc_inc;
  logic [15:0] pc_branch;

  assign opcode    = ir_q[15:12];
  assign op_known  = (opcode == OP_NOP) || (opcode == OP_CMP) || (opcode == OP_B) ||
                     (opcode == OP_ALU) || (opcode == OP_HALT);
  assign pc_inc    = pc_q + 16'd1;
  assign pc_branch = pc_q + {{8{ir_q[7]}}, ir_q[7:0]};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;

    case (state_q)
      S_FETCH: begin
        // Only an acknowledge to a request actually on the bus is accepted.
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!op_known) begin
          illegal_d = 1'b1;
        end
        if (opcode == OP_HALT) begin
          state_d   = S_HALT;
          retired_d = retired_q + 16'd1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (opcode == OP_ALU) begin
          state_d = S_WB;
        end else begin
          state_d   = S_FETCH;
          retired_d = retired_q + 16'd1;
          pc_d      = ((opcode == OP_B) && cmp_f) ? pc_branch : pc_inc;
        end
      end
      S_WB: begin
        state_d   = S_FETCH;
        retired_d = retired_q + 16'd1;
        pc_d      = pc_inc;
      end
      S_HALT: begin
        if (resume) begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    imem_req_d = (state_d == S_FETCH);
    cmp_en_d   = (state_d == S_EXEC) && (ir_d[15:12] == OP_CMP);
    rf_we_d    = (state_d == S_WB);
    halted_d   = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      retired_q  <= 16'h0000;
      illegal_q  <= 1'b0;
      imem_req_q <= 1'b0;
      cmp_en_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      retired_q  <= retired_d;
      illegal_q  <= illegal_d;
      imem_req_q <= imem_req_d;
      cmp_en_q   <= cmp_en_d;
      rf_we_q    <= rf_we_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign cmp_en     = cmp_en_q;
  assign cmp_cond   = ir_q[11:8];
  assign rf_raddr_n = ir_q[7:4];
  assign rf_raddr_m = ir_q[3:0];
  assign rf_we      = rf_we_q;
  assign rf_waddr   = ir_q[11:8];
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule
